// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for a bank of 1-bit registers.
// Grants one requester per cycle; drives registered set_p/data/gnt.
module reg_write_arbiter #(
  parameter int N_REQ  = 4,
  parameter int N_REG  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ-1:0]        req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REG-1:0]        set_p,
  output logic                    data,
  output logic                    addr_err,
  output logic                    busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_nx;
  logic [N_REQ-1:0]  elig;
  logic              found;
  logic [PTR_W-1:0]  win;
  logic [ADDR_W-1:0] win_addr;
  logic              win_data;
  logic              addr_ok;
  logic [N_REQ-1:0]  gnt_nx;
  logic [N_REG-1:0]  set_nx;
  logic              data_nx;
  logic              err_nx;

  assign busy = |req;

  // A requester granted last edge still holds req; mask it once.
  assign elig = req & ~gnt;

  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && idx == i && elig[i]) begin
          found = 1'b1;
          win   = PTR_W'(i);
        end
      end
    end
  end

  always_comb begin
    win_addr = '0;
    win_data = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == PTR_W'(i)) begin
        win_addr = req_addr[i*ADDR_W +: ADDR_W];
        win_data = req_data[i];
      end
    end
  end

  assign addr_ok = int'(win_addr) < N_REG;

  always_comb begin
    gnt_nx  = '0;
    set_nx  = '0;
    data_nx = 1'b0;
    err_nx  = 1'b0;
    ptr_nx  = ptr;
    if (found) begin
      for (int i = 0; i < N_REQ; i++)
        gnt_nx[i] = (win == PTR_W'(i));
      for (int j = 0; j < N_REG; j++)
        set_nx[j] = addr_ok && (win_addr == ADDR_W'(j));
      data_nx = addr_ok & win_data;
      err_nx  = ~addr_ok;
      if (win == PTR_W'(N_REQ - 1))
        ptr_nx = '0;
      else
        ptr_nx = win + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt      <= '0;
      set_p    <= '0;
      data     <= 1'b0;
      addr_err <= 1'b0;
      ptr      <= '0;
    end else begin
      gnt      <= gnt_nx;
      set_p    <= set_nx;
      data     <= data_nx;
      addr_err <= err_nx;
      ptr      <= ptr_nx;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter.
// Two instances: default bank (N_REG=8) and a short bank (N_REG=6).
module tb_reg_write_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [11:0] req_addr;
  logic [3:0]  req_data;
  logic [3:0]  gnt;
  logic [7:0]  set_p;
  logic        data;
  logic        addr_err;
  logic        busy;

  logic [3:0]  req6;
  logic [11:0] req_addr6;
  logic [3:0]  req_data6;
  logic [3:0]  gnt6;
  logic [5:0]  set_p6;
  logic        data6;
  logic        addr_err6;
  logic        busy6;

  logic [7:0]  bank;
  logic [5:0]  bank6;

  int checks;
  int failures;

  reg_write_arbiter #(.N_REQ(4), .N_REG(8), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
    .req_data(req_data), .gnt(gnt), .set_p(set_p), .data(data),
    .addr_err(addr_err), .busy(busy)
  );

  reg_write_arbiter #(.N_REQ(4), .N_REG(6), .ADDR_W(3)) dut6 (
    .clk(clk), .reset(reset), .req(req6), .req_addr(req_addr6),
    .req_data(req_data6), .gnt(gnt6), .set_p(set_p6), .data(data6),
    .addr_err(addr_err6), .busy(busy6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register banks driven by the arbiters' write strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank  <= 8'hFF;
      bank6 <= 6'h15;
    end else begin
      for (int j = 0; j < 8; j++)
        if (set_p[j]) bank[j] <= data;
      for (int j = 0; j < 6; j++)
        if (set_p6[j]) bank6[j] <= data6;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; req_addr = '0; req_data = '0;
    req6 = '0; req_addr6 = '0; req_data6 = '0;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({gnt, set_p, data, addr_err} !== 14'h0) begin
      failures++;
      $display("FAIL reset_outs got=%h exp=0", {gnt, set_p, data, addr_err});
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001;
    req_addr[0 +: 3] = 3'd5;
    req_data[0] = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL single_busy got=%b exp=1", busy);
    end
    step();
    checks++;
    if ({gnt, set_p, data} !== {4'b0001, 8'h20, 1'b1}) begin
      failures++;
      $display("FAIL single_g1 got=%b/%h/%b exp=0001/20/1", gnt, set_p, data);
    end
    step();
    checks++;
    if ({gnt, set_p, data, addr_err} !== 14'h0) begin
      failures++;
      $display("FAIL single_gap got=%b/%h/%b exp=0/0/0", gnt, set_p, data);
    end
    step();
    checks++;
    if ({gnt, set_p, data} !== {4'b0001, 8'h20, 1'b1}) begin
      failures++;
      $display("FAIL single_g2 got=%b/%h/%b exp=0001/20/1", gnt, set_p, data);
    end
    req = '0;
    step();
    checks++;
    if ({gnt, set_p, data} !== 13'h0) begin
      failures++;
      $display("FAIL single_idle got=%b/%h/%b exp=0/0/0", gnt, set_p, data);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [5];
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010;
    exp_seq[2] = 4'b0100; exp_seq[3] = 4'b1000;
    exp_seq[4] = 4'b0001;
    do_reset();
    req = 4'b1111;
    req_addr = {3'd3, 3'd2, 3'd1, 3'd0};
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (gnt !== exp_seq[k]) begin
        failures++;
        $display("FAIL rr_seq%0d gnt=%b exp=%b", k, gnt, exp_seq[k]);
      end
    end
    req = '0;
    step();
  endtask

  task automatic test_ptr_wrap();
    do_reset();
    req = 4'b0100;
    req_addr = {3'd7, 3'd6, 3'd5, 3'd4};
    step();
    checks++;
    if (gnt !== 4'b0100) begin
      failures++;
      $display("FAIL wrap_g2 gnt=%b exp=0100", gnt);
    end
    req = 4'b1001;
    step();
    checks++;
    if ({gnt, set_p} !== {4'b1000, 8'h80}) begin
      failures++;
      $display("FAIL wrap_g3 got=%b/%h exp=1000/80", gnt, set_p);
    end
    step();
    checks++;
    if ({gnt, set_p} !== {4'b0001, 8'h10}) begin
      failures++;
      $display("FAIL wrap_g0 got=%b/%h exp=0001/10", gnt, set_p);
    end
    req = '0;
    step();
  endtask

  task automatic test_addr_err();
    do_reset();
    req6 = 4'b0010;
    req_addr6[3 +: 3] = 3'd7;
    req_data6[1] = 1'b1;
    step();
    checks++;
    if ({gnt6, set_p6, data6, addr_err6} !== {4'b0010, 6'h00, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL err_pulse got=%b/%h/%b/%b exp=0010/00/0/1",
               gnt6, set_p6, data6, addr_err6);
    end
    req6 = '0;
    step();
    checks++;
    if ({gnt6, addr_err6} !== 5'h0) begin
      failures++;
      $display("FAIL err_clear got=%b/%b exp=0000/0", gnt6, addr_err6);
    end
    checks++;
    if (bank6 !== 6'h15) begin
      failures++;
      $display("FAIL err_bank got=%h exp=15", bank6);
    end
  endtask

  task automatic test_same_addr();
    do_reset();
    req = 4'b0011;
    req_addr[0 +: 3] = 3'd3;
    req_addr[3 +: 3] = 3'd3;
    req_data[0] = 1'b0;
    req_data[1] = 1'b1;
    step();
    checks++;
    if ({gnt, set_p, data} !== {4'b0001, 8'h08, 1'b0}) begin
      failures++;
      $display("FAIL same_w0 got=%b/%h/%b exp=0001/08/0", gnt, set_p, data);
    end
    req = 4'b0010;
    step();
    checks++;
    if ({gnt, set_p, data} !== {4'b0010, 8'h08, 1'b1}) begin
      failures++;
      $display("FAIL same_w1 got=%b/%h/%b exp=0010/08/1", gnt, set_p, data);
    end
    checks++;
    if (bank[3] !== 1'b0) begin
      failures++;
      $display("FAIL same_mid bank3=%b exp=0", bank[3]);
    end
    req = '0;
    step();
    checks++;
    if (bank !== 8'hFF) begin
      failures++;
      $display("FAIL same_end bank=%h exp=ff", bank);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b1111;
    req_addr = {3'd3, 3'd2, 3'd1, 3'd0};
    req_data = 4'b1111;
    step();
    step();
    checks++;
    if ({gnt, set_p, data} !== {4'b0010, 8'h02, 1'b1}) begin
      failures++;
      $display("FAIL ar_pre got=%b/%h/%b exp=0010/02/1", gnt, set_p, data);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({gnt, set_p, data, addr_err} !== 14'h0) begin
      failures++;
      $display("FAIL ar_clear got=%b/%h/%b/%b exp=0", gnt, set_p, data, addr_err);
    end
    step();
    reset = 1'b1;
    step();
    checks++;
    if ({gnt, set_p} !== {4'b0001, 8'h01}) begin
      failures++;
      $display("FAIL ar_first got=%b/%h exp=0001/01", gnt, set_p);
    end
    req = '0;
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    req = '0; req_addr = '0; req_data = '0;
    req6 = '0; req_addr6 = '0; req_data6 = '0;
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_ptr_wrap();
    test_addr_err();
    test_same_addr();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
